// File: rtl/sprite_pkg.sv
// sprite_pkg: rotation encodings and ROM sizing helper shared by the sprite blocks
package sprite_pkg;
  typedef enum logic [1:0] {
    ROT_0   = 2'b00,
    ROT_90  = 2'b01,
    ROT_180 = 2'b10,
    ROT_270 = 2'b11
  } rot_t;
  localparam int COORD_W = 6;
  function automatic int addr_w_min(input int w, input int h, input int f);
    return $clog2(w * h * f);
  endfunction
endpackage

// File: rtl/draw_sprite_anim_if.sv
// draw_sprite_anim_if: video timing bundle (counters, strobes and pixel colour)
interface draw_sprite_anim_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;
  modport master(output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave(input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: screen-to-sprite coordinate transform and ROM address computation
module sprite_addr_gen import sprite_pkg::*; #(
  parameter int SPR_W  = 64,
  parameter int SPR_H  = 64,
  parameter int ADDR_W = 14
) (
  input  logic [11:0]       hcount,
  input  logic [11:0]       vcount,
  input  logic [11:0]       x,
  input  logic [11:0]       y,
  input  rot_t              rot,
  input  logic              mirror,
  input  logic              en,
  input  logic [3:0]        frame,
  output logic              hit,
  output logic [ADDR_W-1:0] addr
);
  localparam logic [COORD_W-1:0] W1 = COORD_W'(SPR_W - 1);
  localparam logic [COORD_W-1:0] H1 = COORD_W'(SPR_H - 1);
  logic [COORD_W-1:0] dx, dy, rx, sx, sy;
  // 13-bit bounds so a sprite near the right/bottom edge cannot wrap to 0
  assign hit = en
    && {1'b0, hcount} >= {1'b0, x} && {1'b0, hcount} < {1'b0, x} + 13'(SPR_W)
    && {1'b0, vcount} >= {1'b0, y} && {1'b0, vcount} < {1'b0, y} + 13'(SPR_H);
  assign dx = COORD_W'(hcount - x);
  assign dy = COORD_W'(vcount - y);
  assign rx = rot == ROT_0 ? dx : rot == ROT_90 ? dy : rot == ROT_180 ? W1 - dx : W1 - dy;
  assign sy = rot == ROT_0 ? dy : rot == ROT_90 ? H1 - dx : rot == ROT_180 ? H1 - dy : dx;
  assign sx = mirror ? W1 - rx : rx;
  assign addr = ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H) + ADDR_W'(sy) * ADDR_W'(SPR_W) + ADDR_W'(sx);
endmodule

// File: rtl/draw_sprite_anim.sv
// draw_sprite_anim: two-stage sprite overlay with rotation, mirroring and vsync-paced animation
module draw_sprite_anim import sprite_pkg::*; #(
  parameter int          SPR_W      = 64,
  parameter int          SPR_H      = 64,
  parameter int          FRAMES     = 4,
  parameter int          ANIM_DIV   = 8,
  parameter logic [11:0] TRANSP_KEY = 12'hF0F,
  parameter int          ADDR_W     = 14
) (
  input  logic              pclk,
  input  logic              reset,
  draw_sprite_anim_if.slave  src,
  draw_sprite_anim_if.master dst,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic [1:0]        rotation,
  input  logic              mirror_x,
  input  logic              sprite_en,
  input  logic              anim_en,
  input  logic [11:0]       rgb_pixel,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [3:0]        frame_idx
);
  if (ADDR_W < addr_w_min(SPR_W, SPR_H, FRAMES)) begin : g_aw_check
    $error("ADDR_W too small for SPR_W*SPR_H*FRAMES");
  end
  logic              vs_prev, vs_edge, last_div, last_frame;
  logic [11:0]       sh_x, sh_y;
  rot_t              sh_rot, rot_in;
  logic              sh_mirror, sh_en;
  logic [7:0]        div;
  logic              hit_raw, hit;
  logic [ADDR_W-1:0] addr;
  logic [11:0]       hc_d1, vc_d1, rgb_d1;
  logic              hs_d1, vs_d1, hb_d1, vb_d1, hit_d1;
  assign vs_edge    = src.vsync & ~vs_prev;
  assign last_div   = div == 8'(ANIM_DIV - 1);
  assign last_frame = frame_idx == 4'(FRAMES - 1);
  // quarter turns only make sense for square sprites; fall back to the matching straight turn
  assign rot_in = SPR_W == SPR_H ? rot_t'(rotation) : rot_t'({rotation[1], 1'b0});
  assign hit    = hit_raw & ~src.hblnk & ~src.vblnk;
  sprite_addr_gen #(.SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W)) u_addr_gen (
    .hcount(src.hcount),
    .vcount(src.vcount),
    .x(sh_x),
    .y(sh_y),
    .rot(sh_rot),
    .mirror(sh_mirror),
    .en(sh_en),
    .frame(frame_idx),
    .hit(hit_raw),
    .addr(addr)
  );
  always_ff @(posedge pclk) begin
    if (reset) begin
      vs_prev    <= 1'b0;
      sh_x       <= '0;
      sh_y       <= '0;
      sh_rot     <= ROT_0;
      sh_mirror  <= 1'b0;
      sh_en      <= 1'b0;
      div        <= '0;
      frame_idx  <= '0;
      pixel_addr <= '0;
      hc_d1      <= '0;
      vc_d1      <= '0;
      hs_d1      <= 1'b0;
      vs_d1      <= 1'b0;
      hb_d1      <= 1'b0;
      vb_d1      <= 1'b0;
      rgb_d1     <= '0;
      hit_d1     <= 1'b0;
      dst.hcount <= '0;
      dst.vcount <= '0;
      dst.hsync  <= 1'b0;
      dst.vsync  <= 1'b0;
      dst.hblnk  <= 1'b0;
      dst.vblnk  <= 1'b0;
      dst.rgb    <= '0;
    end else begin
      vs_prev <= src.vsync;
      // placement and animation step only at frame start so a displayed frame is consistent
      if (vs_edge) begin
        sh_x      <= xpos;
        sh_y      <= ypos;
        sh_rot    <= rot_in;
        sh_mirror <= mirror_x;
        sh_en     <= sprite_en;
        if (anim_en) begin
          div <= last_div ? '0 : div + 8'd1;
          if (last_div) frame_idx <= last_frame ? '0 : frame_idx + 4'd1;
        end
      end
      if (hit) pixel_addr <= addr;
      hc_d1      <= src.hcount;
      vc_d1      <= src.vcount;
      hs_d1      <= src.hsync;
      vs_d1      <= src.vsync;
      hb_d1      <= src.hblnk;
      vb_d1      <= src.vblnk;
      rgb_d1     <= src.rgb;
      hit_d1     <= hit;
      dst.hcount <= hc_d1;
      dst.vcount <= vc_d1;
      dst.hsync  <= hs_d1;
      dst.vsync  <= vs_d1;
      dst.hblnk  <= hb_d1;
      dst.vblnk  <= vb_d1;
      dst.rgb    <= (hb_d1 | vb_d1) ? '0 : (hit_d1 && rgb_pixel != TRANSP_KEY) ? rgb_pixel : rgb_d1;
    end
  end
endmodule
